mdu_iter: RTL and testbench

Iterative multiply/divide unit for the RV32M extension, replacing the single-cycle combinational multiply/divide path of the execute stage with a multi-cycle engine parametrised in word width. It accepts one operation at a time through a valid/ready handshake. It runs a shift-add multiply or a restoring divide over WORD_WIDTH iterations and holds the result until the consumer accepts it. It sits beside the ALU in the execute stage; the stage stalls while `ready_o` is low or while a result is pending.

---
 rtl/mdu_iter_if.sv | 24 ++
 rtl/mdu_iter.sv | 153 +++++++++++++++
 tb/tb_mdu_iter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - request/result handshake bundle for the iterative multiply/divide unit
interface mdu_iter_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  valid_i;
    logic                  ready_o;
    logic [2:0]            operator_i;
    logic [WORD_WIDTH-1:0] operand_a_i;
    logic [WORD_WIDTH-1:0] operand_b_i;
    logic                  kill_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [WORD_WIDTH-1:0] result_o;

    modport master (
        output valid_i, operator_i, operand_a_i, operand_b_i, kill_i, ready_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  valid_i, operator_i, operand_a_i, operand_b_i, kill_i, ready_i,
        output ready_o, valid_o, result_o
    );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M multiply/divide: shift-add multiply, restoring divide
// Operands are reduced to magnitudes at accept; the sign is reapplied in FIX.
module mdu_iter #(
    parameter int WORD_WIDTH = 32,
    parameter bit EARLY_OUT  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    mdu_iter_if.slave   bus
);
    localparam int W  = WORD_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST     = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     op_q, op_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   m_q, m_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic           valid_o_q, valid_o_d;
    logic           ready_o_q, ready_o_d;
    logic [W-1:0]   result_o_q, result_o_d;

    logic           is_div_in, sgn_a_in, sgn_b_in, neg_a, neg_b, b_zero, ovf, early;
    logic [W-1:0]   a_mag, b_mag, early_res, div_sel, fix_val;
    logic [W:0]     mul_sum, rem_sh, diff;
    logic [2*W-1:0] mul_next, div_next, prod;

    always_comb begin
        is_div_in = bus.operator_i[2];
        sgn_a_in  = is_div_in ? ~bus.operator_i[0] : (bus.operator_i != 3'b011);
        sgn_b_in  = is_div_in ? ~bus.operator_i[0] : ~bus.operator_i[1];
        neg_a     = sgn_a_in & bus.operand_a_i[W-1];
        neg_b     = sgn_b_in & bus.operand_b_i[W-1];
        a_mag     = neg_a ? -bus.operand_a_i : bus.operand_a_i;
        b_mag     = neg_b ? -bus.operand_b_i : bus.operand_b_i;
        b_zero    = (bus.operand_b_i == '0);
        ovf       = is_div_in & ~bus.operator_i[0] & (bus.operand_a_i == MOST_NEG)
                    & (bus.operand_b_i == '1);
        early     = EARLY_OUT & is_div_in & (b_zero | ovf);
        if (b_zero) early_res = bus.operator_i[1] ? bus.operand_a_i : '1;
        else        early_res = bus.operator_i[1] ? '0 : bus.operand_a_i;

        // Multiply: add the multiplicand into the high half, shift right.
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, m_q} : '0);
        mul_next = {mul_sum, acc_q[W-1:1]};
        // Divide: {remainder, quotient} shifts left, subtract when it fits.
        rem_sh   = acc_q[2*W-1:W-1];
        diff     = rem_sh - {1'b0, m_q};
        div_next = diff[W] ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                           : {diff[W-1:0],   acc_q[W-2:0], 1'b1};

        prod    = neg_q ? -acc_q : acc_q;
        div_sel = op_q[1] ? acc_q[2*W-1:W] : acc_q[W-1:0];
        if (op_q[2])              fix_val = neg_q ? -div_sel : div_sel;
        else if (op_q[1:0] == '0) fix_val = prod[W-1:0];
        else                      fix_val = prod[2*W-1:W];

        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_d      = neg_q;
        m_d        = m_q;
        acc_d      = acc_q;
        valid_o_d  = valid_o_q;
        result_o_d = result_o_q;

        case (state_q)
            IDLE: begin
                if (bus.valid_i && ready_o_q && !bus.kill_i) begin
                    op_d  = bus.operator_i;
                    cnt_d = '0;
                    // A zero divisor yields an all-ones quotient whatever the dividend sign.
                    neg_d = (is_div_in & bus.operator_i[1]) ? neg_a
                          : (neg_a ^ neg_b) & ~(is_div_in & b_zero);
                    m_d   = is_div_in ? b_mag : a_mag;
                    acc_d = {{W{1'b0}}, (is_div_in ? a_mag : b_mag)};
                    if (early) begin
                        state_d    = DONE;
                        valid_o_d  = 1'b1;
                        result_o_d = early_res;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.kill_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    if (cnt_q == LAST) begin
                        state_d = FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FIX: begin
                if (bus.kill_i) begin
                    state_d = IDLE;
                end else begin
                    state_d    = DONE;
                    result_o_d = fix_val;
                end
            end
            default: begin
                if (bus.kill_i || (valid_o_q && bus.ready_i)) begin
                    state_d   = IDLE;
                    valid_o_d = 1'b0;
                end else begin
                    valid_o_d = 1'b1;
                end
            end
        endcase

        ready_o_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            m_q        <= '0;
            acc_q      <= '0;
            valid_o_q  <= 1'b0;
            ready_o_q  <= 1'b1;
            result_o_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            m_q        <= m_d;
            acc_q      <= acc_d;
            valid_o_q  <= valid_o_d;
            ready_o_q  <= ready_o_d;
            result_o_q <= result_o_d;
        end
    end

    assign bus.ready_o  = ready_o_q;
    assign bus.valid_o  = valid_o_q;
    assign bus.result_o = result_o_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed bench for mdu_iter, early-out and fully iterating instances side by side
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_s, kill_s, ready_s;
    logic [2:0]  op_s;
    logic [31:0] a_s, b_s;
    int          checks, errors;

    always #5 clk = ~clk;

    mdu_iter_if #(.WORD_WIDTH(32)) bus_e ();
    mdu_iter_if #(.WORD_WIDTH(32)) bus_n ();

    assign bus_e.valid_i     = valid_s;
    assign bus_e.operator_i  = op_s;
    assign bus_e.operand_a_i = a_s;
    assign bus_e.operand_b_i = b_s;
    assign bus_e.kill_i      = kill_s;
    assign bus_e.ready_i     = ready_s;
    assign bus_n.valid_i     = valid_s;
    assign bus_n.operator_i  = op_s;
    assign bus_n.operand_a_i = a_s;
    assign bus_n.operand_b_i = b_s;
    assign bus_n.kill_i      = kill_s;
    assign bus_n.ready_i     = ready_s;

    mdu_iter #(.WORD_WIDTH(32), .EARLY_OUT(1'b1)) dut_e (.clk(clk), .rst_n(rst_n), .bus(bus_e));
    mdu_iter #(.WORD_WIDTH(32), .EARLY_OUT(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One operation on both units with ready_i held high; e counts edges after the accept edge.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int edge_e, input int edge_n);
        int          got_e, got_n;
        logic [31:0] r_e, r_n;
        got_e = -1; got_n = -1; r_e = '0; r_n = '0;
        @(negedge clk);
        valid_s = 1'b1; op_s = o; a_s = x; b_s = y; ready_s = 1'b1;
        @(negedge clk);
        valid_s = 1'b0; op_s = 3'($urandom); a_s = $urandom; b_s = $urandom;
        check({tag, " ready_o low"}, {31'b0, bus_e.ready_o}, 32'd0);
        for (int e = 0; e < 80 && (got_e < 0 || got_n < 0); e++) begin
            if (got_e < 0 && bus_e.valid_o) begin got_e = e; r_e = bus_e.result_o; end
            if (got_n < 0 && bus_n.valid_o) begin got_n = e; r_n = bus_n.result_o; end
            @(negedge clk);
        end
        check({tag, " result early"}, r_e, exp);
        check({tag, " latency early"}, 32'(got_e), 32'(edge_e));
        check({tag, " result iter"}, r_n, exp);
        check({tag, " latency iter"}, 32'(got_n), 32'(edge_n));
        check({tag, " ready_o back"}, {30'b0, bus_e.ready_o, bus_n.ready_o}, 32'd3);
    endtask

    initial begin
        int          seen, w;
        logic [31:0] held;
        checks = 0; errors = 0;
        rst_n = 1'b0; valid_s = 1'b0; kill_s = 1'b0; ready_s = 1'b0;
        op_s = '0; a_s = '0; b_s = '0;
        @(negedge clk);
        check("reset ready_o", {31'b0, bus_e.ready_o}, 32'd1);
        check("reset valid_o", {31'b0, bus_e.valid_o}, 32'd0);
        check("reset result_o", bus_e.result_o, 32'd0);
        rst_n = 1'b1;

        run_op("MUL 7*-3",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 34);
        run_op("MULH -1*-1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 34);
        run_op("MULHSU -1*max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 34);
        run_op("MULHU max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 34);
        run_op("MULH min*min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 34);
        run_op("DIV -7/2",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 34);
        run_op("REM -7/2",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 34);
        run_op("DIVU 100/7",    3'b101, 32'd100, 32'd7, 32'd14, 34, 34);
        run_op("REMU 100/7",    3'b111, 32'd100, 32'd7, 32'd2, 34, 34);
        run_op("DIV 5/0",       3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 34);
        run_op("REMU 5/0",      3'b111, 32'd5, 32'd0, 32'd5, 0, 34);
        run_op("DIV -5/0",      3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0, 34);
        run_op("REM -5/0",      3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0, 34);
        run_op("DIV ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 34);
        run_op("REM ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 34);

        // kill in IDLE blocks the simultaneous accept
        @(negedge clk);
        valid_s = 1'b1; kill_s = 1'b1; op_s = 3'b000; a_s = 32'd3; b_s = 32'd4;
        @(negedge clk);
        valid_s = 1'b0; kill_s = 1'b0;
        check("idle kill no accept", {30'b0, bus_e.ready_o, bus_n.ready_o}, 32'd3);

        // kill at CALC edge 10
        @(negedge clk);
        valid_s = 1'b1; op_s = 3'b000; a_s = 32'd5; b_s = 32'd6;
        @(negedge clk);
        valid_s = 1'b0;
        repeat (9) @(negedge clk);
        kill_s = 1'b1;
        @(negedge clk);
        kill_s = 1'b0;
        check("calc kill ready_o", {30'b0, bus_e.ready_o, bus_n.ready_o}, 32'd3);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus_e.valid_o || bus_n.valid_o) seen = 1;
        end
        check("calc kill no valid_o", 32'(seen), 32'd0);
        run_op("MUL 3*4 after kill", 3'b000, 32'd3, 32'd4, 32'd12, 34, 34);

        // result held while the consumer stalls
        @(negedge clk);
        ready_s = 1'b0; valid_s = 1'b1; op_s = 3'b001; a_s = 32'hFFFF_FFFE; b_s = 32'h4000_0000;
        @(negedge clk);
        valid_s = 1'b0;
        w = 0;
        while (!bus_e.valid_o && w < 60) begin
            @(negedge clk);
            w++;
        end
        check("hold valid_o seen", {31'b0, bus_e.valid_o}, 32'd1);
        held = bus_e.result_o;
        check("hold MULH value", held, 32'hFFFF_FFFF);
        repeat (5) begin
            @(negedge clk);
            check("hold result_o stable", bus_e.result_o, 32'hFFFF_FFFF);
            check("hold valid_o/ready_o", {30'b0, bus_e.valid_o, bus_e.ready_o}, 32'd2);
        end
        ready_s = 1'b1;
        @(negedge clk);
        check("hold transfer", {30'b0, bus_e.valid_o, bus_e.ready_o}, 32'd1);

        // reset in the middle of CALC
        @(negedge clk);
        valid_s = 1'b1; op_s = 3'b101; a_s = 32'd100; b_s = 32'd7;
        @(negedge clk);
        valid_s = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid reset valid_o", {30'b0, bus_e.valid_o, bus_n.valid_o}, 32'd0);
        check("mid reset ready_o", {30'b0, bus_e.ready_o, bus_n.ready_o}, 32'd3);
        check("mid reset result_o", bus_e.result_o, 32'd0);
        run_op("DIVU after reset", 3'b101, 32'd100, 32'd7, 32'd14, 34, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
